ro_pair_selector: RTL and testbench
===================================

// Module: ro_pair_selector
// PURPOSE
//  Parametrised successor to the fixed 16:1 oscillator mux: selects two distinct ring
//  oscillators (A and B) from an N-wide bank per challenge, via a valid/ready request.
//  Gates both outputs low while selects change, holds them for SETTLE_CYCLES, then opens
//  them with pair_valid high. Sits between the RO bank and the A/B edge counters.
// PARAMETERS
//  N_RO           16                 number of ring-oscillator inputs (>=2)
//  SEL_W          $clog2(N_RO)       select width (derived; do not override)
//  SETTLE_CYCLES  4                  gated cycles after a select change (>=1)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  ro_in      in   N_RO   raw oscillator outputs (asynchronous to clk)
//  req_valid  in   1      new pair request
//  req_ready  out  1      high in IDLE only
//  req_sel_a  in   SEL_W  index of oscillator A
//  req_sel_b  in   SEL_W  index of oscillator B
//  release_i  in   1      measurement done; close gates, return to IDLE
//  ro_a_out   out  1      gated oscillator A
//  ro_b_out   out  1      gated oscillator B
//  pair_valid out  1      high while gates open (ACTIVE)
//  sel_err    out  1      1-cycle pulse on rejected request
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, sel_a/sel_b regs=0, gate_en=0,
//    pair_valid=0, sel_err=0, settle counter=0. ro_a_out/ro_b_out=0 immediately.
//  - ro_x_out = mux(ro_in, sel_x_reg) & gate_en; gate_en is a flop, so the oscillator
//    path stays combinational (no clk sampling of ro_in).
//  - States: IDLE, SETTLE, ACTIVE.
//  - IDLE: req_ready=1. Handshake = req_valid & req_ready on a rising edge.
//    * Reject if sel_a==sel_b or either index >= N_RO: sel_err=1 next cycle for exactly
//      one cycle, selects unchanged, stay IDLE.
//    * Accept: latch sel_a/sel_b, load counter with SETTLE_CYCLES-1, go SETTLE.
//  - SETTLE: gate_en=0, req_ready=0; counter decrements each cycle; at counter==0 go
//    ACTIVE. Accept edge to first pair_valid=1 edge is exactly SETTLE_CYCLES+1 cycles.
//  - ACTIVE: gate_en=1, pair_valid=1. On release_i: next edge state=IDLE, gate_en=0,
//    pair_valid=0 (same edge). New request accepted no earlier than cycle after that.
//  - Ignored: req_valid outside IDLE (ready=0, no error); release_i in IDLE/SETTLE.
//  - release_i and req_valid in the same ACTIVE cycle: release wins; request not taken.
//  - Selects never change while gate_en=1: no runt pulses reach the counters.
//  - Reset mid-SETTLE or mid-ACTIVE: gates close asynchronously, all state as at reset.
//  - Counter width $clog2(SETTLE_CYCLES+1); no wrap (loaded, counts down to 0, stops).
//  - Non-power-of-2 N_RO: indices >= N_RO rejected; mux default output 0 (never X).
// STRUCTURE
//  - Shared package ro_puf_pkg: state enum (IDLE/SETTLE/ACTIVE), clog2 helper, default
//    N_RO and SETTLE_CYCLES constants for the PUF top.
//  - Sub-module ro_mux_n (parametrised N_RO:1 combinational mux, out-of-range -> 0),
//    instantiated twice (A and B). FSM, counter, gate regs stay in this module.
// TESTING
//  - Reset: rst_n=0 with ro_in toggling -> ro_a/b_out=0, pair_valid=0, req_ready=1.
//  - Accept sel_a=3, sel_b=12, SETTLE_CYCLES=4 -> pair_valid rises 5 edges later;
//    ro_a_out follows ro_in[3], ro_b_out follows ro_in[12]; outputs 0 before.
//  - Reject sel_a=sel_b=7 -> sel_err high exactly 1 cycle, stays IDLE, outputs 0.
//  - N_RO=12, sel_a=13 -> sel_err pulse; sel_a=11,sel_b=0 accepted normally.
//  - In ACTIVE assert release_i and req_valid together -> IDLE next edge, gates 0,
//    request not accepted; reissue next cycle -> accepted.
//  - Assert rst_n=0 mid-SETTLE and mid-ACTIVE -> outputs 0 without a clock edge;
//    after release of reset req_ready=1, sel regs=0.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the RO-PUF front end: pair-selector state encoding
// plus the default bank size and settle time.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } ro_state_e;

    localparam int DEF_N_RO          = 16;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Bits needed to hold values 0..v-1; at least 1.
    function automatic int ro_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ro_mux_n.sv
// N:1 combinational oscillator mux; an index with no matching input yields 0 so a
// non-power-of-two bank never produces X on the unused codes.
module ro_mux_n #(
    parameter int N_RO  = 16,
    parameter int SEL_W = $clog2(N_RO)
) (
    input  logic [N_RO-1:0]  ro_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             ro_o
);

    always_comb begin
        ro_o = 1'b0;
        for (int i = 0; i < N_RO; i++) begin
            if (sel_i == SEL_W'(i)) ro_o = ro_i[i];
        end
    end

endmodule

// File: rtl/ro_pair_selector.sv
// Picks two distinct ring oscillators per challenge; gates both outputs low while the
// selects change and opens them, with pair_valid, once the mux has settled.
module ro_pair_selector
    import ro_puf_pkg::*;
#(
    parameter int N_RO          = DEF_N_RO,
    parameter int SEL_W         = $clog2(N_RO),
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_RO-1:0]  ro_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel_a,
    input  logic [SEL_W-1:0] req_sel_b,
    input  logic             release_i,
    output logic             ro_a_out,
    output logic             ro_b_out,
    output logic             pair_valid,
    output logic             sel_err
);

    localparam int              CNT_W    = ro_clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    ro_state_e        state_q;
    logic [SEL_W-1:0] sel_a_q;
    logic [SEL_W-1:0] sel_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             gate_en_q;
    logic             pair_valid_q;
    logic             sel_err_q;
    logic             req_bad;
    logic             mux_a;
    logic             mux_b;

    assign req_ready = (state_q == ST_IDLE);
    assign req_bad   = (req_sel_a == req_sel_b)
                     || (32'(req_sel_a) >= 32'(N_RO))
                     || (32'(req_sel_b) >= 32'(N_RO));

    // Selects only move in IDLE, while gate_en_q is already low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            cnt_q        <= '0;
            gate_en_q    <= 1'b0;
            pair_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            sel_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gate_en_q    <= 1'b0;
                    pair_valid_q <= 1'b0;
                    if (req_valid) begin
                        if (req_bad) begin
                            sel_err_q <= 1'b1;
                        end else begin
                            sel_a_q <= req_sel_a;
                            sel_b_q <= req_sel_b;
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) state_q <= ST_ACTIVE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                // Gates open one edge after entering ACTIVE, giving SETTLE_CYCLES+1
                // cycles from the accepting edge to pair_valid.
                ST_ACTIVE: begin
                    if (release_i) begin
                        state_q      <= ST_IDLE;
                        gate_en_q    <= 1'b0;
                        pair_valid_q <= 1'b0;
                    end else begin
                        gate_en_q    <= 1'b1;
                        pair_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    gate_en_q    <= 1'b0;
                    pair_valid_q <= 1'b0;
                end
            endcase
        end
    end

    ro_mux_n #(.N_RO(N_RO), .SEL_W(SEL_W)) u_mux_a (
        .ro_i  (ro_in),
        .sel_i (sel_a_q),
        .ro_o  (mux_a)
    );

    ro_mux_n #(.N_RO(N_RO), .SEL_W(SEL_W)) u_mux_b (
        .ro_i  (ro_in),
        .sel_i (sel_b_q),
        .ro_o  (mux_b)
    );

    assign ro_a_out   = mux_a & gate_en_q;
    assign ro_b_out   = mux_b & gate_en_q;
    assign pair_valid = pair_valid_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_ro_pair_selector.sv
// Directed bench for ro_pair_selector: a 16-input instance and a 12-input instance.
module tb_ro_pair_selector;

    logic        clk;
    logic        rst_n;

    logic [15:0] ro_in0;
    logic        req_valid0, req_ready0, release0;
    logic [3:0]  sel_a0, sel_b0;
    logic        ro_a0, ro_b0, pv0, err0;

    logic [11:0] ro_in1;
    logic        req_valid1, req_ready1, release1;
    logic [3:0]  sel_a1, sel_b1;
    logic        ro_a1, ro_b1, pv1, err1;

    int n_checks = 0;
    int n_fail   = 0;

    ro_pair_selector #(.N_RO(16), .SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in0),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_sel_a(sel_a0), .req_sel_b(sel_b0), .release_i(release0),
        .ro_a_out(ro_a0), .ro_b_out(ro_b0), .pair_valid(pv0), .sel_err(err0)
    );

    ro_pair_selector #(.N_RO(12), .SETTLE_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in1),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_sel_a(sel_a1), .req_sel_b(sel_b1), .release_i(release1),
        .ro_a_out(ro_a1), .ro_b_out(ro_b1), .pair_valid(pv1), .sel_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ro_in0 = 16'($urandom);
            ro_in1 = 12'($urandom);
            #2;
            chk("reset ro_a", ro_a0, 1'b0);
            chk("reset ro_b", ro_b0, 1'b0);
        end
        chk("reset pair_valid", pv0, 1'b0);
        chk("reset req_ready", req_ready0, 1'b1);
        chk("reset sel_err", err0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-reset req_ready", req_ready0, 1'b1);
    endtask

    task automatic test_accept();
        ro_in0 = 16'hFFFF;
        sel_a0 = 4'd3; sel_b0 = 4'd12; req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        chk("accept ready low", req_ready0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("settle pair_valid low", pv0, 1'b0);
            chk("settle ro_a gated", ro_a0, 1'b0);
            chk("settle ro_b gated", ro_b0, 1'b0);
        end
        tick();
        chk("pair_valid after 5 edges", pv0, 1'b1);
        for (int p = 0; p < 4; p++) begin
            logic [15:0] pat;
            case (p)
                0: pat = 16'h0008;
                1: pat = 16'h1000;
                2: pat = 16'hEFF7;
                default: pat = 16'h1008;
            endcase
            ro_in0 = pat;
            #1;
            chk("active ro_a follows ro_in[3]", ro_a0, pat[3]);
            chk("active ro_b follows ro_in[12]", ro_b0, pat[12]);
        end
        req_valid0 = 1'b1; sel_a0 = 4'd5; sel_b0 = 4'd6;
        tick();
        chk("active ignores req no err", err0, 1'b0);
        chk("active ignores req stays valid", pv0, 1'b1);
        req_valid0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        ro_in0 = 16'hFFFF;
        release0 = 1'b1; req_valid0 = 1'b1; sel_a0 = 4'd1; sel_b0 = 4'd2;
        tick();
        release0 = 1'b0;
        chk("release -> idle ready", req_ready0, 1'b1);
        chk("release pair_valid low", pv0, 1'b0);
        chk("release ro_a gated", ro_a0, 1'b0);
        chk("release ro_b gated", ro_b0, 1'b0);
        tick();
        req_valid0 = 1'b0;
        chk("reissue accepted", req_ready0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        chk("reissue pair_valid", pv0, 1'b1);
        ro_in0 = 16'h0002;
        #1;
        chk("reissue ro_a follows ro_in[1]", ro_a0, 1'b1);
        chk("reissue ro_b follows ro_in[2]", ro_b0, 1'b0);
        release0 = 1'b1;
        tick();
        release0 = 1'b0;
        chk("second release idle", req_ready0, 1'b1);
    endtask

    task automatic test_reject();
        ro_in0 = 16'hFFFF;
        sel_a0 = 4'd7; sel_b0 = 4'd7; req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        chk("reject sel_err pulse", err0, 1'b1);
        chk("reject stays idle", req_ready0, 1'b1);
        chk("reject outputs low", ro_a0, 1'b0);
        chk("reject sel_a unchanged", dut0.sel_a_q == 4'd1, 1'b1);
        tick();
        chk("reject sel_err one cycle", err0, 1'b0);
        chk("reject still idle", req_ready0, 1'b1);
        release0 = 1'b1;
        tick();
        release0 = 1'b0;
        chk("release in idle ignored", req_ready0, 1'b1);
    endtask

    task automatic test_nonpow2();
        ro_in1 = 12'hFFF;
        sel_a1 = 4'd13; sel_b1 = 4'd0; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("n12 out of range sel_err", err1, 1'b1);
        chk("n12 out of range idle", req_ready1, 1'b1);
        tick();
        chk("n12 sel_err cleared", err1, 1'b0);
        sel_a1 = 4'd11; sel_b1 = 4'd0; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("n12 accept no err", err1, 1'b0);
        chk("n12 accept ready low", req_ready1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("n12 pair_valid not yet", pv1, 1'b0);
        tick();
        chk("n12 pair_valid", pv1, 1'b1);
        ro_in1 = 12'h800;
        #1;
        chk("n12 ro_a follows ro_in[11]", ro_a1, 1'b1);
        chk("n12 ro_b follows ro_in[0]", ro_b1, 1'b0);
        ro_in1 = 12'h001;
        #1;
        chk("n12 ro_a low", ro_a1, 1'b0);
        chk("n12 ro_b high", ro_b1, 1'b1);
        release1 = 1'b1;
        tick();
        release1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        ro_in0 = 16'hFFFF;
        sel_a0 = 4'd4; sel_b0 = 4'd9; req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid-settle reset ready", req_ready0, 1'b1);
        chk("mid-settle reset pair_valid", pv0, 1'b0);
        chk("mid-settle sel_a cleared", dut0.sel_a_q == 4'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sel_a0 = 4'd4; sel_b0 = 4'd9; req_valid0 = 1'b1;
        tick();
        req_valid0 = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre-reset active ro_a", ro_a0, 1'b1);
        chk("pre-reset active pair_valid", pv0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-active reset ro_a", ro_a0, 1'b0);
        chk("mid-active reset ro_b", ro_b0, 1'b0);
        chk("mid-active reset pair_valid", pv0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after reset ready", req_ready0, 1'b1);
        chk("after reset sel_a zero", dut0.sel_a_q == 4'd0, 1'b1);
        chk("after reset sel_b zero", dut0.sel_b_q == 4'd0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        ro_in0 = '0; ro_in1 = '0;
        req_valid0 = 1'b0; release0 = 1'b0; sel_a0 = '0; sel_b0 = '0;
        req_valid1 = 1'b0; release1 = 1'b0; sel_a1 = '0; sel_b1 = '0;
        test_reset();
        test_accept();
        test_back_to_back();
        test_reject();
        test_nonpow2();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000ns");
        $fatal(1);
    end

endmodule
